pipe_stage_reg: RTL



---
 rtl/pipe_pkg.sv | 26 ++
 rtl/pipe_skid_slot.sv | 43 ++++
 rtl/pipe_stage_reg.sv | 125 ++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_pkg
// Description : Shared constants for the parametrised inter-stage pipeline
//               register: default widths, control-bit positions and the
//               payload-width helper used to size the storage slots.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    // Default widths of the five-stage MIPS datapath
    localparam int c_DATA_W = 32;
    localparam int c_RD_W   = 5;

    // Bit positions inside the control bundle
    localparam int c_CTRL_REGWRITE = 0;
    localparam int c_CTRL_MEMTOREG = 1;

    // Total bits stored per entry: {data words, rd, ctrl}
    function automatic int payload_w(input int num_data, input int data_w,
                                     input int rd_w, input int ctrl_w);
        return num_data * data_w + rd_w + ctrl_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_skid_slot.sv
`default_nettype none
// ============================================================================
// Module      : pipe_skid_slot
// Description : One storage slot of the pipeline stage: a valid bit plus a
//               payload register. The payload loads only on i_load (valid
//               bit carries the semantics); i_clear drops the valid bit only.
//               i_load takes precedence over i_clear.
// Ports       : clk, reset (sync, active-high), i_load, i_clear,
//               i_payload -> o_valid, o_payload
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_skid_slot #(
    parameter int PAYLOAD_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_load,
    input  logic                 i_clear,
    input  logic [PAYLOAD_W-1:0] i_payload,
    output logic                 o_valid,
    output logic [PAYLOAD_W-1:0] o_payload
);

    logic                 r_valid;
    logic [PAYLOAD_W-1:0] r_payload;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid   <= 1'b0;
            r_payload <= '0;
        end else if (i_load) begin
            r_valid   <= 1'b1;
            r_payload <= i_payload;
        end else if (i_clear) begin
            r_valid   <= 1'b0;
        end
    end

    assign o_valid   = r_valid;
    assign o_payload = r_payload;

endmodule
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_reg
// Description : Parametrised inter-stage pipeline register with valid/ready
//               handshake and a 2-entry skid buffer (main slot M drives the
//               outputs, skid slot S absorbs the entry in flight when the
//               downstream stalls). in_ready depends only on registered state.
//               flush empties both slots; bubbles can squash out_ctrl.
// Ports       : clk, reset, flush,
//               in_valid/in_ready/in_data/in_rd/in_ctrl   (upstream side)
//               out_valid/out_ready/out_data/out_rd/out_ctrl (downstream side)
//               stall_cnt, bubble_cnt (only with PIPE_STAGE_PERF_EN defined)
// Options     : `define PIPE_STAGE_PERF_EN adds saturating stall/bubble
//               performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W      = c_DATA_W,
    parameter int NUM_DATA    = 2,
    parameter int RD_W        = c_RD_W,
    parameter int CTRL_W      = 2,
    parameter bit SQUASH_CTRL = 1'b1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [NUM_DATA*DATA_W-1:0] in_data,
    input  logic [RD_W-1:0]            in_rd,
    input  logic [CTRL_W-1:0]          in_ctrl,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [NUM_DATA*DATA_W-1:0] out_data,
    output logic [RD_W-1:0]            out_rd,
`ifdef PIPE_STAGE_PERF_EN
    output logic [31:0]                stall_cnt,
    output logic [31:0]                bubble_cnt,
`endif
    output logic [CTRL_W-1:0]          out_ctrl
);

    localparam int c_DW = NUM_DATA * DATA_W;
    localparam int c_PW = payload_w(NUM_DATA, DATA_W, RD_W, CTRL_W);

    logic            w_m_valid, w_s_valid;
    logic [c_PW-1:0] w_m_payload, w_s_payload;
    logic [c_PW-1:0] w_in_payload, w_m_next;
    logic            w_in_fire, w_out_fire, w_m_free;
    logic            w_m_load, w_m_clear, w_s_load, w_s_clear;

    assign w_in_payload = {in_data, in_rd, in_ctrl};

    // S is only ever occupied while M is occupied, so S valid means "full".
    assign in_ready   = ~w_s_valid;
    assign out_valid  = w_m_valid;
    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = out_valid & out_ready;
    assign w_m_free   = ~w_m_valid | w_out_fire;

    // M refills from S first (oldest entry), otherwise straight from input.
    assign w_m_next  = w_s_valid ? w_s_payload : w_in_payload;
    assign w_m_load  = ~flush & w_m_free & (w_s_valid | w_in_fire);
    assign w_m_clear = flush | (w_m_free & ~w_s_valid & ~w_in_fire);

    // S only captures when M is occupied and not draining this cycle.
    assign w_s_load  = ~flush & w_in_fire & ~w_m_free;
    assign w_s_clear = flush | (w_m_free & w_s_valid);

    pipe_skid_slot #(.PAYLOAD_W(c_PW)) u_slot_m (
        .clk       (clk),
        .reset     (reset),
        .i_load    (w_m_load),
        .i_clear   (w_m_clear),
        .i_payload (w_m_next),
        .o_valid   (w_m_valid),
        .o_payload (w_m_payload)
    );

    pipe_skid_slot #(.PAYLOAD_W(c_PW)) u_slot_s (
        .clk       (clk),
        .reset     (reset),
        .i_load    (w_s_load),
        .i_clear   (w_s_clear),
        .i_payload (w_in_payload),
        .o_valid   (w_s_valid),
        .o_payload (w_s_payload)
    );

    assign out_data = w_m_payload[c_PW-1 -: c_DW];
    assign out_rd   = w_m_payload[CTRL_W +: RD_W];

    generate
        if (SQUASH_CTRL) begin : g_squash
            // A bubble must never carry RegWrite/MemWrite downstream.
            assign out_ctrl = w_m_valid ? w_m_payload[CTRL_W-1:0] : '0;
        end else begin : g_raw_ctrl
            assign out_ctrl = w_m_payload[CTRL_W-1:0];
        end
    endgenerate

`ifdef PIPE_STAGE_PERF_EN
    logic [31:0] r_stall_cnt, r_bubble_cnt;

    // Saturating counters; flush deliberately leaves them untouched.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            if (in_valid && !in_ready && (r_stall_cnt != 32'hFFFF_FFFF))
                r_stall_cnt <= r_stall_cnt + 32'd1;
            if (!out_valid && out_ready && (r_bubble_cnt != 32'hFFFF_FFFF))
                r_bubble_cnt <= r_bubble_cnt + 32'd1;
        end
    end

    assign stall_cnt  = r_stall_cnt;
    assign bubble_cnt = r_bubble_cnt;
`endif

endmodule
`default_nettype wire
